// File: rtl/dlx_bus_pkg.sv
// Shared definitions for the extended DLX data-bus memory responder:
// FSM state encoding, default geometry constants and the latched bus-cycle record.
package dlx_bus_pkg;

   localparam int DLX_ADDR_W      = 10;
   localparam int DLX_DATA_W      = 32;
   localparam int DLX_WAIT_CYCLES = 2;
   localparam int DLX_BUS_AW      = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } bus_state_t;

   // One bus cycle as captured on the REQ sampling edge. The data field is
   // sized by DLX_DATA_W, so the responder's DATA_W must stay at that width.
   typedef struct packed {
      logic [DLX_BUS_AW-1:0] addr;
      logic [DLX_DATA_W-1:0] data;
      logic                  wr;
   } bus_cycle_t;

   // Counter width able to hold the value n (at least one bit).
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/dlx_sram.sv
// Single-port synchronous SRAM used as backing store by the DLX memory responder.
// Read-before-write on a shared address; contents are not initialised and there is no reset.
module dlx_sram
   import dlx_bus_pkg::*;
#(
   parameter int ADDR_W = DLX_ADDR_W,
   parameter int DATA_W = DLX_DATA_W
) (
   input  logic              CLK,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Registered read of the addressed word every cycle, write when enabled.
   always_ff @(posedge CLK) begin
      if (we) begin
         mem[addr] <= din;
      end
      dout <= mem[addr];
   end

endmodule

// File: rtl/dlx_mem_responder.sv
// Memory-side responder for the extended DLX data bus: four-phase REQ/ACK handshake,
// WAIT_CYCLES wait states, then a single-word read or write of the internal SRAM.
// Optional build macro DLX_ADDR_FAULT_EN: when defined, a nonzero address above the
// word index faults the cycle (no memory operation, DO cleared, ERR raised with ACK);
// when undefined, the upper address bits alias and ERR stays low.
module dlx_mem_responder
   import dlx_bus_pkg::*;
#(
   parameter int ADDR_W      = DLX_ADDR_W,
   parameter int DATA_W      = DLX_DATA_W,
   parameter int WAIT_CYCLES = DLX_WAIT_CYCLES
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [31:0]       AO,
   input  logic [DATA_W-1:0] DI,
   input  logic              WR,
   input  logic              REQ,
   output logic [DATA_W-1:0] DO,
   output logic              ACK,
   output logic              ERR,
   output logic              BUSY
);

   localparam int CNT_W = cnt_width(WAIT_CYCLES);

   bus_state_t        state;
   bus_cycle_t        lat;
   logic [CNT_W-1:0]  wait_cnt;
   logic              ack_reg;
   logic              err_reg;
   logic              busy_reg;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] ram_dout;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic              addr_fault;

`ifdef DLX_ADDR_FAULT_EN
   // Any set bit above the word index makes the cycle an address fault.
   assign addr_fault = (lat.addr >> ADDR_W) != '0;
`else
   // Upper address bits are deliberately ignored so addresses alias into the array.
   logic unused_upper_addr;
   assign unused_upper_addr = ^(lat.addr >> ADDR_W);
   assign addr_fault        = 1'b0;
`endif

   // While idle the SRAM looks up the live address, so the word for the accepted
   // cycle is already in ram_dout by the time ACCESS is reached, even with no wait states.
   assign ram_addr = (state == IDLE) ? AO[ADDR_W-1:0] : lat.addr[ADDR_W-1:0];

   // The write fires only in ACCESS, never during reset and never for a faulted address.
   assign ram_we = (state == ACCESS) && lat.wr && !addr_fault && !RESET;

   dlx_sram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_sram (
      .CLK  (CLK),
      .we   (ram_we),
      .addr (ram_addr),
      .din  (DATA_W'(lat.data)),
      .dout (ram_dout)
   );

   // Bus-cycle FSM: capture the request, count wait states, access memory, then
   // hold ACK until the requester drops REQ. All outputs are registered here.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= IDLE;
         lat      <= '0;
         wait_cnt <= '0;
         ack_reg  <= 1'b0;
         err_reg  <= 1'b0;
         busy_reg <= 1'b0;
         rd_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (REQ) begin
                  lat.addr <= AO;
                  lat.data <= DLX_DATA_W'(DI);
                  lat.wr   <= WR;
                  busy_reg <= 1'b1;
                  if (WAIT_CYCLES == 0) begin
                     state <= ACCESS;
                  end else begin
                     wait_cnt <= CNT_W'(WAIT_CYCLES);
                     state    <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (wait_cnt != '0) begin
                  wait_cnt <= wait_cnt - 1'b1;
               end else begin
                  state <= ACCESS;
               end
            end
            ACCESS: begin
               ack_reg <= 1'b1;
               state   <= DONE;
               if (addr_fault) begin
                  err_reg <= 1'b1;
                  rd_data <= '0;
               end else if (!lat.wr) begin
                  rd_data <= ram_dout;
               end
            end
            DONE: begin
               if (!REQ) begin
                  ack_reg  <= 1'b0;
                  err_reg  <= 1'b0;
                  busy_reg <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign DO   = rd_data;
   assign ACK  = ack_reg;
   assign ERR  = err_reg;
   assign BUSY = busy_reg;

endmodule

// File: tb/tb_dlx_mem_responder.sv
// Directed testbench for dlx_mem_responder with hand-computed expected values.
// Honours DLX_ADDR_FAULT_EN for the fault-related expectations.
module tb_dlx_mem_responder;

   localparam int W = 2;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [31:0] AO;
   logic [31:0] DI;
   logic        WR;
   logic        REQ;
   logic [31:0] DO;
   logic        ACK;
   logic        ERR;
   logic        BUSY;

   int vectors     = 0;
   int miscompares = 0;

`ifdef DLX_ADDR_FAULT_EN
   localparam bit FAULT_ON = 1'b1;
`else
   localparam bit FAULT_ON = 1'b0;
`endif

   dlx_mem_responder #(
      .ADDR_W      (10),
      .DATA_W      (32),
      .WAIT_CYCLES (W)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .AO    (AO),
      .DI    (DI),
      .WR    (WR),
      .REQ   (REQ),
      .DO    (DO),
      .ACK   (ACK),
      .ERR   (ERR),
      .BUSY  (BUSY)
   );

   // Free-running clock, 10 time units per period.
   always #5 CLK = ~CLK;

   // Single comparison point: counts every vector and reports any miscompare.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Present a request; after the sampling edge scramble the inputs to prove they were
   // latched. Returns the index of the edge after which ACK was seen (edge 0 = sampling).
   task automatic applyStimulus(input logic [31:0] ao, input logic [31:0] di, input bit wr,
                                output int ack_edge);
      int n;
      AO  = ao;
      DI  = di;
      WR  = wr;
      REQ = 1'b1;
      n   = 0;
      do begin
         tick();
         n++;
         AO = $urandom;
         DI = $urandom;
         WR = ~wr;
         if (n == 1) checkOutput("busy_after_req", {31'd0, BUSY}, 32'd1);
      end while (!ACK && n < 20);
      ack_edge = n - 1;
   endtask

   // Drop REQ and confirm the handshake closes on the next edge.
   task automatic finishCycle(input string tag);
      REQ = 1'b0;
      AO  = 32'd0;
      DI  = 32'd0;
      WR  = 1'b0;
      tick();
      checkOutput({tag, "_ack_low"}, {31'd0, ACK}, 32'd0);
      checkOutput({tag, "_err_low"}, {31'd0, ERR}, 32'd0);
      checkOutput({tag, "_idle"}, {31'd0, BUSY}, 32'd0);
   endtask

   // Full read transaction with latency and data checks.
   task automatic readWord(input string tag, input logic [31:0] ao, input logic [31:0] exp_do,
                           input bit exp_err);
      int e;
      applyStimulus(ao, 32'd0, 1'b0, e);
      checkOutput({tag, "_lat"}, e, W + 2);
      checkOutput({tag, "_do"}, DO, exp_do);
      checkOutput({tag, "_err"}, {31'd0, ERR}, {31'd0, exp_err});
      finishCycle(tag);
   endtask

   // Full write transaction; DO must not move on a legal write.
   task automatic writeWord(input string tag, input logic [31:0] ao, input logic [31:0] di,
                            input logic [31:0] exp_do, input bit exp_err);
      int e;
      applyStimulus(ao, di, 1'b1, e);
      checkOutput({tag, "_lat"}, e, W + 2);
      checkOutput({tag, "_do"}, DO, exp_do);
      checkOutput({tag, "_err"}, {31'd0, ERR}, {31'd0, exp_err});
      finishCycle(tag);
   endtask

   initial begin
      int ack_cnt;
      int first_ack;
      logic [31:0] do_at_ack;

      RESET = 1'b1;
      AO    = 32'd0;
      DI    = 32'd0;
      WR    = 1'b0;
      REQ   = 1'b0;
      tick();
      tick();
      checkOutput("rst_ack", {31'd0, ACK}, 32'd0);
      checkOutput("rst_err", {31'd0, ERR}, 32'd0);
      checkOutput("rst_busy", {31'd0, BUSY}, 32'd0);
      checkOutput("rst_do", DO, 32'd0);
      RESET = 1'b0;
      tick();

      // Basic write then read back, plus the top word of the array.
      writeWord("wr5", 32'h0000_0005, 32'hDEAD_BEEF, 32'd0, 1'b0);
      readWord("rd5", 32'h0000_0005, 32'hDEAD_BEEF, 1'b0);
      writeWord("wr3ff", 32'h0000_03FF, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0);
      readWord("rd3ff", 32'h0000_03FF, 32'h1234_5678, 1'b0);

      // Out-of-range address: faulted or aliased onto index 2.
      writeWord("wr2", 32'h0000_0002, 32'h0BAD_F00D, 32'h1234_5678, 1'b0);
      readWord("rd2", 32'h0000_0002, 32'h0BAD_F00D, 1'b0);
      writeWord("wrflt", 32'h0001_0002, 32'hCAFE_F00D,
                FAULT_ON ? 32'd0 : 32'h0BAD_F00D, FAULT_ON);
      readWord("rd2post", 32'h0000_0002, FAULT_ON ? 32'h0BAD_F00D : 32'hCAFE_F00D, 1'b0);
      readWord("rdflt", 32'h0001_0005, FAULT_ON ? 32'd0 : 32'hDEAD_BEEF, FAULT_ON);

      // Reset while the write sits in WAIT: cycle abandoned, word untouched.
      writeWord("wr7", 32'h0000_0007, 32'h1111_1111, FAULT_ON ? 32'd0 : 32'hDEAD_BEEF, 1'b0);
      AO  = 32'h0000_0007;
      DI  = 32'h2222_2222;
      WR  = 1'b1;
      REQ = 1'b1;
      tick();
      tick();
      RESET = 1'b1;
      REQ   = 1'b0;
      tick();
      checkOutput("midrst_ack", {31'd0, ACK}, 32'd0);
      checkOutput("midrst_busy", {31'd0, BUSY}, 32'd0);
      checkOutput("midrst_do", DO, 32'd0);
      RESET = 1'b0;
      tick();
      readWord("rd7", 32'h0000_0007, 32'h1111_1111, 1'b0);

      // REQ held for one edge only: the cycle completes with a single ACK pulse.
      AO  = 32'h0000_0005;
      WR  = 1'b0;
      REQ = 1'b1;
      tick();
      REQ       = 1'b0;
      ack_cnt   = 0;
      first_ack = 0;
      do_at_ack = 32'd0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (ACK) begin
            ack_cnt++;
            if (first_ack == 0) begin
               first_ack = i;
               do_at_ack = DO;
            end
         end
      end
      checkOutput("early_first", first_ack, W + 2);
      checkOutput("early_count", ack_cnt, 1);
      checkOutput("early_do", do_at_ack, 32'hDEAD_BEEF);
      checkOutput("early_idle", {31'd0, BUSY}, 32'd0);

      // REQ held across DONE: ACK stays up, no new cycle starts.
      begin
         int e;
         applyStimulus(32'h0000_03FF, 32'd0, 1'b0, e);
         checkOutput("hold_lat", e, W + 2);
         AO = 32'h0000_0005;
         for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("hold_ack", {31'd0, ACK}, 32'd1);
            checkOutput("hold_busy", {31'd0, BUSY}, 32'd1);
            checkOutput("hold_do", DO, 32'h1234_5678);
         end
         finishCycle("hold");
         readWord("after_hold", 32'h0000_0005, 32'hDEAD_BEEF, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
